// File: rtl/seg_pkg.sv
// Shared definitions for the segment display path: FSM encoding, default
// geometry and the segment-pattern type used by converter, cursor control and driver.
package seg_pkg;

  localparam int SEG_CHAR_CT = 8;
  localparam int SEG_SEG_W   = 8;

  localparam logic [SEG_SEG_W-1:0] SEG_BLANK = '0;

  typedef logic [SEG_SEG_W-1:0] seg_pat_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_REDRAW = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_GAP    = 3'd4
  } seg_state_e;

endpackage

// File: rtl/seg_shadow_buf.sv
// Shadow copy of every display digit: indexed write, shift-left with insert at
// the top digit, clear-all, and combinational read by index.
module seg_shadow_buf
  import seg_pkg::*;
#(
  parameter int               CHAR_CT = SEG_CHAR_CT,
  parameter int               SEG_W   = SEG_SEG_W,
  parameter logic [SEG_W-1:0] BLANK   = SEG_W'(SEG_BLANK),
  localparam int              IDX_W   = $clog2(CHAR_CT)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [SEG_W-1:0] i_wr_data,
  input  logic             i_shift_en,
  input  logic [SEG_W-1:0] i_shift_data,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [SEG_W-1:0] o_rd_data
);

  logic [SEG_W-1:0] r_mem [CHAR_CT];

  // Clear outranks shift, shift outranks a plain write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < CHAR_CT; i++) r_mem[i] <= BLANK;
    end else if (i_clr) begin
      for (int i = 0; i < CHAR_CT; i++) r_mem[i] <= BLANK;
    end else if (i_shift_en) begin
      for (int i = 0; i < CHAR_CT - 1; i++) r_mem[i] <= r_mem[i+1];
      r_mem[CHAR_CT-1] <= i_shift_data;
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/seg_cursor_ctrl.sv
// Cursor controller between the ASCII-to-segment converter and the 7-segment
// driver: places characters, handles home/clear, and scrolls via full redraw.
module seg_cursor_ctrl
  import seg_pkg::*;
#(
  parameter int               CHAR_CT    = SEG_CHAR_CT,
  parameter int               SEG_W      = SEG_SEG_W,
  parameter bit               SCROLL_EN  = 1'b1,
  parameter int               COMMIT_GAP = 4,
  parameter logic [SEG_W-1:0] BLANK      = SEG_W'(SEG_BLANK),
  localparam int              IDX_W      = $clog2(CHAR_CT),
  localparam int              CUR_W      = IDX_W + 1
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [SEG_W-1:0] seg_in,
  input  logic             seg_in_vld,
  input  logic             home_req,
  input  logic             clear_req,
  output logic             commit_char,
  output logic [IDX_W-1:0] char_sel,
  output logic [SEG_W-1:0] seg_out,
  output logic             clear_buffer,
  output logic             busy,
  output logic [CUR_W-1:0] cursor,
  output logic             overrun
);

  localparam int             CNT_W    = $clog2(COMMIT_GAP + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(COMMIT_GAP - 1);
  localparam logic [CUR_W-1:0] CUR_FULL = CUR_W'(CHAR_CT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHAR_CT - 1);

  seg_state_e       r_state;
  seg_state_e       w_state_nxt;
  logic [CUR_W-1:0] r_cursor;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_gap_cnt;
  logic             r_redraw;
  logic             r_clr_pend;
  logic             r_home_pend;
  logic             r_overrun;

  logic             w_idle;
  logic             w_full;
  logic             w_clr_go;
  logic             w_home_go;
  logic             w_wr_go;
  logic             w_scroll;
  logic             w_drop;
  logic             w_gap_done;
  logic [IDX_W-1:0] w_wr_idx;
  logic [SEG_W-1:0] w_rd_data;
  logic             w_commit;
  logic             w_clear;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_full     = (r_cursor == CUR_FULL);
  assign w_clr_go   = w_idle && (clear_req || r_clr_pend);
  assign w_home_go  = w_idle && !w_clr_go && (home_req || r_home_pend);
  assign w_wr_go    = w_idle && !w_clr_go && !w_home_go && seg_in_vld;
  assign w_scroll   = w_wr_go && w_full && SCROLL_EN;
  // A full display without scrolling wraps the write back to digit 0.
  assign w_wr_idx   = w_full ? '0 : r_cursor[IDX_W-1:0];
  assign w_drop     = seg_in_vld && !w_wr_go;
  assign w_gap_done = (r_state == ST_GAP) && (r_gap_cnt == GAP_LAST);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_clr_go)     w_state_nxt = ST_CLEAR;
        else if (w_wr_go) w_state_nxt = w_scroll ? ST_REDRAW : ST_WRITE;
      end
      ST_WRITE, ST_REDRAW: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_GAP;
      end
      ST_CLEAR: begin
        w_clear     = 1'b1;
        w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (w_gap_done)
          w_state_nxt = (r_redraw && (r_idx != IDX_LAST)) ? ST_REDRAW : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cursor    <= '0;
      r_idx       <= '0;
      r_gap_cnt   <= '0;
      r_redraw    <= 1'b0;
      r_clr_pend  <= 1'b0;
      r_home_pend <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + CNT_W'(1) : '0;

      if (w_clr_go) begin
        r_cursor    <= '0;
        r_clr_pend  <= 1'b0;
        r_home_pend <= 1'b0;
        r_overrun   <= 1'b0;
      end else if (w_home_go) begin
        r_cursor    <= '0;
        r_home_pend <= 1'b0;
      end else if (w_wr_go) begin
        if (!w_full)        r_cursor <= r_cursor + CUR_W'(1);
        else if (!SCROLL_EN) r_cursor <= CUR_W'(1);
        r_idx    <= w_scroll ? '0 : w_wr_idx;
        r_redraw <= w_scroll;
      end

      if (!w_idle && clear_req) r_clr_pend  <= 1'b1;
      if (!w_idle && home_req)  r_home_pend <= 1'b1;

      // Redraw index advances after each gap and wraps to 0 only as redraw ends.
      if (w_gap_done && r_redraw) begin
        r_idx <= r_idx + IDX_W'(1);
        if (r_idx == IDX_LAST) r_redraw <= 1'b0;
      end

      if (w_drop) r_overrun <= 1'b1;
    end
  end

  seg_shadow_buf #(
    .CHAR_CT (CHAR_CT),
    .SEG_W   (SEG_W),
    .BLANK   (BLANK)
  ) u_buf (
    .i_clk        (sys_clk),
    .i_rst_n      (rst_n),
    .i_clr        (w_clr_go),
    .i_wr_en      (w_wr_go && !w_scroll),
    .i_wr_idx     (w_wr_idx),
    .i_wr_data    (seg_in),
    .i_shift_en   (w_scroll),
    .i_shift_data (seg_in),
    .i_rd_idx     (r_idx),
    .o_rd_data    (w_rd_data)
  );

  assign commit_char  = w_commit;
  assign char_sel     = w_commit ? r_idx : '0;
  assign seg_out      = w_commit ? w_rd_data : '0;
  assign clear_buffer = w_clear;
  assign busy         = !w_idle;
  assign cursor       = r_cursor;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_seg_cursor_ctrl.sv
// Directed bench for seg_cursor_ctrl: one scrolling instance and one wrapping
// instance driven by the same stimulus.
module tb_seg_cursor_ctrl;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_in = 8'h00;
  logic       seg_in_vld = 1'b0;
  logic       home_req = 1'b0;
  logic       clear_req = 1'b0;

  logic       a_commit, a_clr, a_busy, a_ovr;
  logic [2:0] a_sel;
  logic [7:0] a_seg;
  logic [3:0] a_cur;
  logic       b_commit, b_clr, b_busy, b_ovr;
  logic [2:0] b_sel;
  logic [7:0] b_seg;
  logic [3:0] b_cur;

  int n_chk = 0;
  int n_pass = 0;

  always #5 sys_clk = ~sys_clk;

  seg_cursor_ctrl #(.CHAR_CT(8), .SEG_W(8), .SCROLL_EN(1'b1), .COMMIT_GAP(4), .BLANK(8'h00)) u_dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .seg_in(seg_in), .seg_in_vld(seg_in_vld),
    .home_req(home_req), .clear_req(clear_req), .commit_char(a_commit), .char_sel(a_sel),
    .seg_out(a_seg), .clear_buffer(a_clr), .busy(a_busy), .cursor(a_cur), .overrun(a_ovr));

  seg_cursor_ctrl #(.CHAR_CT(8), .SEG_W(8), .SCROLL_EN(1'b0), .COMMIT_GAP(4), .BLANK(8'h00)) u_dut_ns (
    .sys_clk(sys_clk), .rst_n(rst_n), .seg_in(seg_in), .seg_in_vld(seg_in_vld),
    .home_req(home_req), .clear_req(clear_req), .commit_char(b_commit), .char_sel(b_sel),
    .seg_out(b_seg), .clear_buffer(b_clr), .busy(b_busy), .cursor(b_cur), .overrun(b_ovr));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset;
    seg_in_vld = 1'b0;
    home_req   = 1'b0;
    clear_req  = 1'b0;
    rst_n      = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle;
    int k = 0;
    while ((a_busy || b_busy) && k < 300) begin
      tick;
      k++;
    end
    if (k >= 300) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Leaves the bench in the cycle right after the strobe edge (commit cycle).
  task automatic strobe(input logic [7:0] p);
    seg_in     = p;
    seg_in_vld = 1'b1;
    tick;
    seg_in_vld = 1'b0;
  endtask

  task automatic write_seq(input int n);
    for (int i = 1; i <= n; i++) begin
      wait_idle;
      strobe(8'(i));
    end
    wait_idle;
  endtask

  function automatic logic [7:0] buf_or_a();
    logic [7:0] acc = 8'h00;
    for (int i = 0; i < 8; i++) acc |= u_dut.u_buf.r_mem[i];
    return acc;
  endfunction

  initial begin
    logic [7:0] pats [3];
    int k, busy_cnt, bad_gap, b_extra, ncom, last_com, clr_at, clr_cyc, both;
    pats[0] = 8'h06; pats[1] = 8'h5B; pats[2] = 8'h4F;

    // Reset state and basic writes
    do_reset;
    chk("rst_outputs", {a_commit, a_clr, a_busy, a_ovr, a_sel, a_seg}, 32'd0);
    chk("rst_cursor", a_cur, 32'd0);
    for (int i = 0; i < 3; i++) begin
      wait_idle;
      repeat (4) tick;
      strobe(pats[i]);
      chk($sformatf("write_%0d", i), {a_commit, a_sel, a_seg}, {1'b1, 3'(i), pats[i]});
    end
    wait_idle;
    chk("cursor_after_3", a_cur, 32'd3);

    // Fill, then 9th write: scroll redraw on A, wrap to digit 0 on B
    do_reset;
    write_seq(8);
    chk("cursor_full", a_cur, 32'd8);
    strobe(8'h09);
    chk("wrap_commit", {b_commit, b_sel, b_seg}, {1'b1, 3'd0, 8'h09});
    k = 0; busy_cnt = 0; bad_gap = 0; b_extra = 0;
    while (a_busy && k < 100) begin
      if (k % 5 == 0)
        chk($sformatf("redraw_%0d", k / 5), {a_commit, a_sel, a_seg}, {1'b1, 3'(k / 5), 8'(k / 5 + 2)});
      else if (a_commit || a_clr)
        bad_gap++;
      if (k > 0 && b_commit) b_extra++;
      busy_cnt++;
      tick;
      k++;
    end
    chk("redraw_busy_cycles", busy_cnt, 32'd40);
    chk("redraw_gap_quiet", bad_gap, 32'd0);
    chk("cursor_stays_full", a_cur, 32'd8);
    chk("wrap_no_redraw", b_extra, 32'd0);
    chk("wrap_cursor", b_cur, 32'd1);

    // Clear request during a redraw
    do_reset;
    write_seq(8);
    strobe(8'h09);
    ncom = 0; last_com = -1; clr_at = -1; clr_cyc = 0; both = 0;
    for (int j = 0; j < 120; j++) begin
      if (a_commit) begin ncom++; last_com = j; end
      if (a_clr) begin clr_cyc++; if (clr_at < 0) clr_at = j; end
      if (a_commit && a_clr) both++;
      clear_req = (j == 10);
      tick;
    end
    clear_req = 1'b0;
    chk("clr_redraw_commits", ncom, 32'd8);
    chk("clr_pulse_width", clr_cyc, 32'd1);
    chk("clr_after_redraw", (clr_at - last_com) >= 5, 32'd1);
    chk("clr_commit_overlap", both, 32'd0);
    chk("clr_cursor", a_cur, 32'd0);
    chk("clr_buffer_blank", buf_or_a(), 32'd0);

    // Overrun: strobe while busy, then strobe with home in IDLE
    do_reset;
    seg_in = 8'h11; seg_in_vld = 1'b1;
    tick;
    chk("ovr_first_commit", {a_commit, a_sel, a_seg}, {1'b1, 3'd0, 8'h11});
    seg_in = 8'h22;
    tick;
    seg_in_vld = 1'b0;
    chk("ovr_busy_drop", {a_ovr, a_commit}, {1'b1, 1'b0});
    wait_idle;
    chk("ovr_cursor_1", a_cur, 32'd1);
    seg_in = 8'h33; seg_in_vld = 1'b1; home_req = 1'b1;
    tick;
    seg_in_vld = 1'b0; home_req = 1'b0;
    chk("home_drop", {a_commit, a_busy, a_cur, a_ovr}, {1'b0, 1'b0, 4'd0, 1'b1});
    tick;
    chk("home_no_late_commit", a_commit, 32'd0);
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    chk("clear_pulse", {a_clr, a_ovr}, {1'b1, 1'b0});
    wait_idle;
    chk("ovr_cleared", a_ovr, 32'd0);

    // Reset during redraw at index 3
    do_reset;
    write_seq(8);
    strobe(8'h09);
    repeat (15) tick;
    chk("redraw_idx3", {a_commit, a_sel, a_seg}, {1'b1, 3'd3, 8'h05});
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {a_commit, a_busy, a_cur}, 32'd0);
    chk("midrst_buffer", buf_or_a(), 32'd0);
    tick;
    rst_n = 1'b1;
    ncom = 0;
    for (int j = 0; j < 20; j++) begin
      if (a_commit || a_clr) ncom++;
      tick;
    end
    chk("midrst_quiet", ncom, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
